// File: rtl/fsm_stimulus_checker_if.sv
// ---------------------------------------------------------------------------
// fsm_stimulus_checker_if
// Symbol input channel of the FSM stimulus checker.
//
// Signals:
//   in_valid - producer has a symbol on in_x/in_last
//   in_ready - checker can accept a symbol this cycle
//   in_x     - 2-bit X symbol {X1,X2}
//   in_last  - marks the final symbol of a test
//
// Handshake: a symbol transfers on every rising clock edge where
// in_valid & in_ready are both high. in_ready does not depend on in_valid.
// While in_valid is high and in_ready is low, the producer holds in_x and
// in_last stable until the transfer edge.
//
// Modports: master = symbol producer, slave = checker.
// ---------------------------------------------------------------------------
interface fsm_stimulus_checker_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_x;
  logic       in_last;

  modport master (output in_valid, output in_x, output in_last, input in_ready);
  modport slave  (input in_valid, input in_x, input in_last, output in_ready);
endinterface

// File: rtl/fsm_stimulus_checker.sv
// ---------------------------------------------------------------------------
// fsm_stimulus_checker
// Initiator/checker for a 2-bit X -> 2-bit Z Mealy FSM. X symbols come in
// over a valid/ready channel and are buffered in a FIFO. One symbol per cycle
// is driven onto dut_x. The DUT's combinational dut_z is compared in the same
// cycle against an internal shadow model of the FSM.
//
// Ports:
//   clk, reset   - clock; asynchronous active-high reset
//   s_in         - symbol channel (in_valid/in_ready/in_x/in_last)
//   run          - 1: pop one symbol per cycle; 0: hold FIFO, drive bubbles
//   clr          - in DONE: return to ACTIVE and clear counters/flags
//   dut_x        - registered X driven to the DUT
//   dut_z        - DUT output {Z1,Z2}
//   exp_z        - expected Z for the current cycle (combinational)
//   mismatch     - 1-cycle pulse after a failed compare
//   err_cnt      - saturating mismatch count
//   busy         - FIFO non-empty or a valid symbol on dut_x
//   done, pass   - last symbol compared; pass = no mismatches
//   dbg_state    - {ctl state, x_vld, shadow model state}
// ---------------------------------------------------------------------------
module fsm_stimulus_checker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  fsm_stimulus_checker_if.slave s_in,
  input  logic                 run,
  input  logic                 clr,
  output logic [1:0]           dut_x,
  input  logic [1:0]           dut_z,
  output logic [1:0]           exp_z,
  output logic                 mismatch,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [3:0]           dbg_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {CTL_ACTIVE = 1'b0, CTL_DONE = 1'b1} ctl_t;
  typedef enum logic [1:0] {ST_A = 2'b00, ST_B = 2'b01, ST_C = 2'b10, ST_D = 2'b11} mst_t;

  // FIFO entries hold {last, x}
  logic [2:0]       r_mem [DEPTH];
  logic [AW:0]      r_wptr, r_rptr;

  ctl_t             r_ctl;
  mst_t             r_st;
  logic [1:0]       r_dut_x;
  logic             r_x_vld;
  logic             r_x_last;
  logic             r_last_seen;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_done;
  logic             r_pass;

  logic             w_empty, w_full, w_ready, w_push, w_pop;
  logic [2:0]       w_head;
  mst_t             w_nst;
  logic             w_z2;
  logic [1:0]       w_exp_z;
  logic             w_fail, w_fin;
  logic [CNT_W-1:0] w_err_next;

  // Extra pointer bit distinguishes full from empty
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  // in_ready ignores a same-cycle pop so it stays a pure function of state
  assign w_ready = (r_ctl == CTL_ACTIVE) && !w_full && !r_last_seen;
  assign w_push  = s_in.in_valid && w_ready;
  assign w_pop   = (r_ctl == CTL_ACTIVE) && run && !w_empty;

  // Shadow model: next state and Z2 from current state and dut_x
  always_comb begin
    w_nst = r_st;
    w_z2  = 1'b0;
    case (r_st)
      ST_A: begin
        if (r_dut_x == 2'b11) begin w_nst = ST_D; w_z2 = 1'b1; end
        else                        w_nst = ST_A;
      end
      ST_B: begin
        case (r_dut_x)
          2'b11:   w_nst = ST_B;
          2'b10:   begin w_nst = ST_B; w_z2 = 1'b1; end
          default: w_nst = ST_A;
        endcase
      end
      ST_C: begin
        if (r_dut_x == 2'b10) begin w_nst = ST_B; w_z2 = 1'b1; end
        else                        w_nst = ST_C;
      end
      ST_D: begin
        case (r_dut_x)
          2'b11:   begin w_nst = ST_D; w_z2 = 1'b1; end
          2'b10:   w_nst = ST_A;
          default: w_nst = ST_C;
        endcase
      end
      default: w_nst = ST_A;
    endcase
  end

  assign w_exp_z = {r_st[1], w_z2};

  // Bubbles (x_vld=0) are never compared
  assign w_fail     = r_x_vld && (dut_z != w_exp_z);
  assign w_err_next = (w_fail && (r_err_cnt != {CNT_W{1'b1}})) ? r_err_cnt + CNT_W'(1) : r_err_cnt;
  assign w_fin      = (r_ctl == CTL_ACTIVE) && r_x_vld && r_x_last;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {s_in.in_last, s_in.in_x};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_ctl       <= CTL_ACTIVE;
      r_st        <= ST_A;
      r_dut_x     <= 2'b00;
      r_x_vld     <= 1'b0;
      r_x_last    <= 1'b0;
      r_last_seen <= 1'b0;
      r_mismatch  <= 1'b0;
      r_err_cnt   <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      // The DUT is clocked every cycle, so the model tracks bubbles too
      r_st       <= w_nst;
      r_mismatch <= w_fail;
      r_err_cnt  <= w_err_next;

      if (w_push) begin
        r_wptr <= r_wptr + (AW+1)'(1);
        if (s_in.in_last) r_last_seen <= 1'b1;
      end

      if (w_pop) begin
        r_rptr   <= r_rptr + (AW+1)'(1);
        r_dut_x  <= w_head[1:0];
        r_x_vld  <= 1'b1;
        r_x_last <= w_head[2];
      end else begin
        r_dut_x  <= 2'b00;
        r_x_vld  <= 1'b0;
        r_x_last <= 1'b0;
      end

      case (r_ctl)
        CTL_ACTIVE: begin
          if (w_fin) begin
            r_ctl  <= CTL_DONE;
            r_done <= 1'b1;
            r_pass <= (w_err_next == '0);
          end
        end
        CTL_DONE: begin
          // Model state is kept: clr does not reset the DUT
          if (clr) begin
            r_ctl       <= CTL_ACTIVE;
            r_err_cnt   <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_last_seen <= 1'b0;
          end
        end
        default: r_ctl <= CTL_ACTIVE;
      endcase
    end
  end

  assign s_in.in_ready = w_ready;
  assign dut_x         = r_dut_x;
  assign exp_z         = w_exp_z;
  assign mismatch      = r_mismatch;
  assign err_cnt       = r_err_cnt;
  assign busy          = !w_empty || r_x_vld;
  assign done          = r_done;
  assign pass          = r_pass;
  assign dbg_state     = {r_ctl, r_x_vld, r_st};

endmodule

// File: tb/tb_fsm_stimulus_checker.sv
module tb_fsm_stimulus_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic run, clr, stub;

  fsm_stimulus_checker_if ifc_a ();
  fsm_stimulus_checker_if ifc_b ();

  // Instance b (CNT_W=2, always stubbed DUT) sees the same stream as a
  assign ifc_b.in_valid = ifc_a.in_valid;
  assign ifc_b.in_x     = ifc_a.in_x;
  assign ifc_b.in_last  = ifc_a.in_last;

  logic [1:0] dut_x_a, dut_z_a, exp_z_a;
  logic       mismatch_a, busy_a, done_a, pass_a;
  logic [7:0] err_cnt_a;
  logic [3:0] dbg_a;

  logic [1:0] dut_x_b, dut_z_b, exp_z_b;
  logic       mismatch_b, busy_b, done_b, pass_b;
  logic [1:0] err_cnt_b;
  logic [3:0] dbg_b;

  fsm_stimulus_checker #(.DEPTH(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .s_in(ifc_a), .run(run), .clr(clr),
    .dut_x(dut_x_a), .dut_z(dut_z_a), .exp_z(exp_z_a), .mismatch(mismatch_a),
    .err_cnt(err_cnt_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .dbg_state(dbg_a)
  );

  fsm_stimulus_checker #(.DEPTH(4), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .s_in(ifc_b), .run(run), .clr(clr),
    .dut_x(dut_x_b), .dut_z(dut_z_b), .exp_z(exp_z_b), .mismatch(mismatch_b),
    .err_cnt(err_cnt_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .dbg_state(dbg_b)
  );

  // ---------------- reference Mealy FSM (the "DUT" under check) ----------------
  // returns {next_state, Z2}
  function automatic logic [2:0] fsm_step(input logic [1:0] st, input logic [1:0] x);
    case ({st, x})
      4'b00_00, 4'b00_01, 4'b00_10: return 3'b00_0;
      4'b00_11:                     return 3'b11_1;
      4'b01_00, 4'b01_01:           return 3'b00_0;
      4'b01_11:                     return 3'b01_0;
      4'b01_10:                     return 3'b01_1;
      4'b10_10:                     return 3'b01_1;
      4'b10_00, 4'b10_01, 4'b10_11: return 3'b10_0;
      4'b11_00, 4'b11_01:           return 3'b10_0;
      4'b11_11:                     return 3'b11_1;
      default:                      return 3'b00_0;  // D,10 -> A/0
    endcase
  endfunction

  logic [1:0] ref_st;
  logic [2:0] ref_out;
  logic [1:0] ref_z;
  assign ref_out = fsm_step(ref_st, dut_x_a);
  assign ref_z   = {ref_st[1], ref_out[0]};
  always @(posedge clk or posedge reset)
    if (reset) ref_st <= 2'b00;
    else       ref_st <= ref_out[2:1];

  assign dut_z_a = stub ? 2'b00 : ref_z;
  assign dut_z_b = 2'b00;

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];
  logic [1:0] sb_e;
  int         exp_err;
  logic       pend_mm;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle monitor on instance a: exp_z, mismatch pulse, err_cnt, symbol order
  always @(negedge clk) begin
    if (!reset) begin
      check("exp_z", 32'(exp_z_a), 32'(ref_z));
      check("mismatch", 32'(mismatch_a), 32'(pend_mm));
      check("err_cnt", 32'(err_cnt_a), 32'(exp_err));
      pend_mm = 1'b0;
      if (dbg_a[2]) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'(exp_q.size() == 0), 32'(0));
        end else begin
          sb_e = exp_q.pop_front();
          check("dut_x", 32'(dut_x_a), 32'(sb_e));
        end
        pend_mm = (dut_z_a != ref_z);
        if (pend_mm && exp_err < 255) exp_err++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge
  task automatic push_sym(input logic [1:0] x, input logic last);
    logic acc;
    acc = 1'b0;
    ifc_a.in_valid = 1'b1;
    ifc_a.in_x     = x;
    ifc_a.in_last  = last;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = ifc_a.in_ready;
      @(posedge clk);
      #1;
    end
    if (acc) exp_q.push_back(x);
    check("accept", 32'(acc), 32'(1));
    ifc_a.in_valid = 1'b0;
    ifc_a.in_last  = 1'b0;
  endtask

  task automatic push_stream();
    push_sym(2'b11, 1'b0);
    push_sym(2'b11, 1'b0);
    push_sym(2'b00, 1'b0);
    push_sym(2'b10, 1'b0);
    push_sym(2'b10, 1'b0);
    push_sym(2'b01, 1'b1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && !done_a; i++) @(negedge clk);
    check("done", 32'(done_a), 32'(1));
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr     = 1'b0;
    exp_err = 0;
    @(negedge clk);
    check("clr_done", 32'(done_a), 32'(0));
    check("clr_pass", 32'(pass_a), 32'(0));
    check("clr_ready", 32'(ifc_a.in_ready), 32'(1));
    check("clr_err_b", 32'(err_cnt_b), 32'(0));
    check("clr_done_b", 32'(done_b), 32'(0));
    check("clr_ready_b", 32'(ifc_b.in_ready), 32'(1));
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    run = 1'b1; clr = 1'b0; stub = 1'b0;
    ifc_a.in_valid = 1'b0; ifc_a.in_x = 2'b00; ifc_a.in_last = 1'b0;
    exp_err = 0; pend_mm = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_ready", 32'(ifc_a.in_ready), 32'(1));
    check("rst_busy", 32'(busy_a), 32'(0));
    check("rst_dut_x", 32'(dut_x_a), 32'(0));
    check("rst_exp_z", 32'(exp_z_a), 32'(0));
    check("rst_err", 32'(err_cnt_a), 32'(0));
    check("rst_mm", 32'(mismatch_a), 32'(0));
    check("rst_done", 32'(done_a), 32'(0));
    check("rst_pass", 32'(pass_a), 32'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    // Correct DUT, full stream
    push_stream();
    @(negedge clk);
    check("last_seen_ready", 32'(ifc_a.in_ready), 32'(0));
    wait_done();
    check("t1_pass", 32'(pass_a), 32'(1));
    check("t1_err", 32'(err_cnt_a), 32'(0));
    check("t1_done_b", 32'(done_b), 32'(1));
    check("t1_sat_b", 32'(err_cnt_b), 32'(3));
    check("t1_pass_b", 32'(pass_b), 32'(0));
    do_clr();

    // Stubbed DUT (dut_z = 00)
    stub = 1'b1;
    push_stream();
    wait_done();
    check("t2_err", 32'(err_cnt_a), 32'(5));
    check("t2_pass", 32'(pass_a), 32'(0));
    check("t2_sat_b", 32'(err_cnt_b), 32'(3));
    do_clr();
    stub = 1'b0;

    // run=0 fills FIFO; 5th symbol held until run=1
    run = 1'b0;
    push_sym(2'b01, 1'b0);
    push_sym(2'b10, 1'b0);
    push_sym(2'b11, 1'b0);
    push_sym(2'b00, 1'b0);
    ifc_a.in_valid = 1'b1; ifc_a.in_x = 2'b10; ifc_a.in_last = 1'b1;
    @(negedge clk);
    check("full_ready", 32'(ifc_a.in_ready), 32'(0));
    check("full_busy", 32'(busy_a), 32'(1));
    check("hold_dut_x", 32'(dut_x_a), 32'(0));
    run = 1'b1;
    check("full_nobypass", 32'(ifc_a.in_ready), 32'(0));
    @(posedge clk);
    #1;
    push_sym(2'b10, 1'b1);
    wait_done();
    check("t3_pass", 32'(pass_a), 32'(1));
    do_clr();

    // Bubble between 11 and 10 moves model D -> C
    push_sym(2'b11, 1'b0);
    @(posedge clk);
    #1;
    push_sym(2'b10, 1'b1);
    check("bubble_dut_x", 32'(dut_x_a), 32'(0));
    @(posedge clk);
    #1;
    check("t4_dut_x", 32'(dut_x_a), 32'(2'b10));
    check("t4_exp_z", 32'(exp_z_a), 32'(2'b11));
    check("t4_state_c", 32'(dbg_a[1:0]), 32'(2'b10));
    wait_done();
    check("t4_state_b", 32'(dbg_a[1:0]), 32'(2'b01));
    check("t4_pass", 32'(pass_a), 32'(1));
    do_clr();

    // Reset with symbols queued
    run = 1'b0;
    push_sym(2'b01, 1'b0);
    push_sym(2'b11, 1'b0);
    push_sym(2'b10, 1'b0);
    @(negedge clk);
    check("q_busy", 32'(busy_a), 32'(1));
    #2;
    reset = 1'b1;
    exp_q.delete();
    exp_err = 0;
    pend_mm = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rr_ready", 32'(ifc_a.in_ready), 32'(1));
    check("rr_busy", 32'(busy_a), 32'(0));
    check("rr_dut_x", 32'(dut_x_a), 32'(0));
    check("rr_err", 32'(err_cnt_a), 32'(0));
    check("rr_exp_z", 32'(exp_z_a), 32'(0));
    run = 1'b1;
    repeat (4) @(negedge clk);
    check("rr_drained", 32'(busy_a), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fsm_stimulus_checker.md
Name: fsm_stimulus_checker

Overview:
- Initiator/checker end of the 2-bit X -> 2-bit Z Mealy FSM interface.
- Accepts a stream of X symbols over a valid/ready handshake and buffers them in a FIFO.
- Drives each symbol onto dut_x, samples the DUT's dut_z in the same cycle, and compares it against an internal shadow model of the FSM.
- Counts mismatches and reports done/pass; used as the self-checking harness for structural and behavioural FSM implementations.

Parameters:
- DEPTH, 4, symbol FIFO depth (power of 2, >=2)
- CNT_W, 8, width of the mismatch counter

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- in_valid  input  1  symbol-present qualifier
- in_ready  output  1  checker can accept a symbol this cycle
- in_x  input  2  X symbol {X1,X2}
- in_last  input  1  marks the final symbol of a test
- run  input  1  1 = pop FIFO each cycle; 0 = hold FIFO, apply bubbles
- clr  input  1  sync; in DONE: return to ACTIVE and zero counters
- dut_x  output  2  registered X driven to the DUT
- dut_z  input  2  DUT output {Z1,Z2}, combinational from dut_x/state
- exp_z  output  2  combinational expected Z for the current cycle
- mismatch  output  1  registered 1-cycle pulse after a failed compare
- err_cnt  output  CNT_W  saturating mismatch count
- busy  output  1  FIFO non-empty or a valid symbol on dut_x
- done  output  1  last symbol compared
- pass  output  1  valid only with done; 1 iff err_cnt==0

Behaviour:
- Reset values: dut_x=00, x_vld=0, model state=A, FIFO empty, err_cnt=0, mismatch=0, done=0, pass=0, ctl=ACTIVE, last_seen=0.
- Shadow model states: A=00, B=01, C=10, D=11. It advances every clock edge with the current dut_x, bubbles included, because the DUT is clocked every cycle.
- Transition table, written X -> next/Z2:
  - A: 00,01,10 -> A/0; 11 -> D/1.
  - B: 00,01 -> A/0; 11 -> B/0; 10 -> B/1.
  - C: 00,01,11 -> C/0; 10 -> B/1.
  - D: 00,01 -> C/0; 11 -> D/1; 10 -> A/0.
- exp_z = {state[1], Z2}.
- Handshake and FIFO:
  - in_ready = ACTIVE & ~full & ~last_seen.
  - Push on in_valid & in_ready. A push with in_last=1 sets last_seen.
  - No full-bypass: in_ready stays low when full, even if a pop occurs that cycle.
- Pop and drive:
  - In ACTIVE with run=1 and FIFO non-empty, pop at the edge: dut_x <= head, x_vld <= 1, x_last <= head.last.
  - Otherwise dut_x <= 00 and x_vld <= 0 (bubble).
  - Simultaneous push and pop is allowed.
- Latency: a symbol pushed at edge k into an empty FIFO reaches dut_x after edge k+1. It is compared during cycle k+1..k+2, and err_cnt/mismatch update at edge k+2.
- Compare:
  - When x_vld and dut_z != exp_z: mismatch <= 1 next edge, err_cnt <= err_cnt+1, saturating at all-ones.
  - Otherwise mismatch <= 0.
  - Bubbles are never compared.
- Control FSM:
  - ACTIVE -> DONE at the edge where x_vld & x_last is compared. At that edge done <= 1 and pass <= (final err_cnt incl. this compare == 0).
  - DONE: in_ready=0, no pops, bubbles 00 driven, model keeps tracking.
  - DONE & clr -> ACTIVE. That edge clears err_cnt, done, pass and last_seen. The model state is not cleared, since the DUT is not reset by clr.
  - clr in ACTIVE is ignored.
- busy = ~empty | x_vld.
- Reset mid-stream: all state returns to reset values immediately. Partially queued symbols are discarded.

Test Plan:
- Reset, run=1; push 11,11,00,10,10,01 (last on 01) with a correct DUT -> dut_z/exp_z sequence 01,11,10,11,01,00; mismatch never set; done=1, pass=1, err_cnt=0.
- Same stream with dut_z stubbed to constant 00 -> mismatches on the 11,11,00,10,10 symbols; err_cnt=5, pass=0 at done; mismatch pulses are one cycle each.
- run=0, push 5 symbols back-to-back -> in_ready falls after the 4th accept; the 5th is held. Set run=1 -> the FIFO drains one per cycle, the 5th is accepted, and the order is preserved on dut_x.
- Push 11 (state -> D), run=0 for 1 cycle (bubble 00 moves model and DUT to C), then push 10 last -> expected Z=11 and next state B; pass=1, confirming bubbles are tracked.
- CNT_W=2, stubbed DUT, 5 mismatching symbols -> err_cnt saturates at 3, pass=0; then clr -> err_cnt=0, done=0, in_ready=1.
- Assert reset with 3 symbols queued -> in_ready=1, busy=0, dut_x=00, err_cnt=0, exp_z=00 (state A) on the next cycle.
